traffic_sensor_req: RTL

Vehicle-sensor front end for the traffic light controller. It synchronises and debounces a raw inductive-loop input and holds a service request on the controller's `din` input until the vehicle has seen green and left. It watches the controller's 3-bit light output to close the loop, counts detected vehicles, and flags starvation. It sits between the road-side loop detector and `signals`.

---
 rtl/traffic_pkg.sv | 18 +
 rtl/sensor_debounce.sv | 50 +++++
 rtl/traffic_sensor_req.sv | 129 ++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared light codes and sensor FSM state encoding for the traffic light vehicle sensor.
package traffic_pkg;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRequest = 2'd1,
        StServed  = 2'd2
    } sensor_state_e;

    function automatic logic light_code_legal(input logic [2:0] code);
        return (code == LIGHT_RED) || (code == LIGHT_YELLOW) || (code == LIGHT_GREEN);
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser plus run-length debounce for the raw inductive-loop input.
module sensor_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_loop_raw,
    output logic o_present
);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_present;
    logic [7:0] r_cnt;
    logic       w_present_d;
    logic [7:0] w_cnt_d;
    logic [7:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + 8'd1;

    // Count consecutive samples that disagree with the debounced level.
    always_comb begin
        w_present_d = r_present;
        w_cnt_d     = '0;
        if (r_sync2 != r_present) begin
            if (w_cnt_inc == 8'(DEBOUNCE_CYCLES)) begin
                w_present_d = ~r_present;
            end else begin
                w_cnt_d = w_cnt_inc;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_present <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_loop_raw;
            r_sync2   <= r_sync1;
            r_present <= w_present_d;
            r_cnt     <= w_cnt_d;
        end
    end

    assign o_present = r_present;

endmodule

// File: rtl/traffic_sensor_req.sv
// Vehicle-sensor front end: holds a service request until the vehicle has seen green and left.
// Optional light-code checker is built when TRAFFIC_LIGHT_CHECK_EN is defined.
module traffic_sensor_req
    import traffic_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned MAX_WAIT        = 200,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_loop_raw,
    input  logic [2:0]       i_lights,
    output logic             o_req,
    output logic [CNT_W-1:0] o_vehicle_cnt,
    output logic             o_wait_timeout,
    output logic             o_illegal_code
);

    localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

    sensor_state_e    r_state, w_state_d;
    logic             r_req, w_req_d;
    logic [CNT_W-1:0] r_vehicle_cnt, w_vehicle_cnt_d;
    logic [WaitW-1:0] r_wait, w_wait_d;
    logic             r_timeout, w_timeout_d;
    logic             r_present_prev;
    logic             w_present;

    sensor_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_loop_raw (i_loop_raw),
        .o_present  (w_present)
    );

    always_comb begin
        w_state_d       = r_state;
        w_vehicle_cnt_d = r_vehicle_cnt;
        w_wait_d        = r_wait;
        w_timeout_d     = r_timeout;
        unique case (r_state)
            StIdle: begin
                if (w_present && !r_present_prev) begin
                    w_state_d = StRequest;
                    w_wait_d  = '0;
                    if (r_vehicle_cnt != '1) w_vehicle_cnt_d = r_vehicle_cnt + CNT_W'(1);
                end
            end
            StRequest: begin
                // Green takes priority over a simultaneous departure.
                if (i_lights == LIGHT_GREEN) begin
                    w_state_d   = StServed;
                    w_timeout_d = 1'b0;
                end else if (!w_present) begin
                    w_state_d = StIdle;
                end else begin
                    if (r_wait != WaitW'(MAX_WAIT)) w_wait_d = r_wait + WaitW'(1);
                    if (r_wait >= WaitW'(MAX_WAIT - 1)) w_timeout_d = 1'b1;
                end
            end
            StServed: begin
                if (!w_present) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
        w_req_d = (w_state_d == StRequest) || ((w_state_d == StServed) && w_present);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= StIdle;
            r_req          <= 1'b0;
            r_vehicle_cnt  <= '0;
            r_wait         <= '0;
            r_timeout      <= 1'b0;
            r_present_prev <= 1'b0;
        end else begin
            r_state        <= w_state_d;
            r_req          <= w_req_d;
            r_vehicle_cnt  <= w_vehicle_cnt_d;
            r_wait         <= w_wait_d;
            r_timeout      <= w_timeout_d;
            r_present_prev <= w_present;
        end
    end

    assign o_req          = r_req;
    assign o_vehicle_cnt  = r_vehicle_cnt;
    assign o_wait_timeout = r_timeout;

`ifdef TRAFFIC_LIGHT_CHECK_EN
    logic [2:0] r_lights_q;
    logic [2:0] r_lights_p;
    logic [1:0] r_lights_vld;
    logic       r_illegal;
    logic       w_illegal_d;

    // Validity bits keep the reset value of the history from being judged.
    always_comb begin
        w_illegal_d = r_illegal;
        if (r_lights_vld[0] && !light_code_legal(r_lights_q)) w_illegal_d = 1'b1;
        if (r_lights_vld[1] && (r_lights_p == LIGHT_GREEN) && (r_lights_q == LIGHT_RED)) begin
            w_illegal_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lights_q   <= '0;
            r_lights_p   <= '0;
            r_lights_vld <= '0;
            r_illegal    <= 1'b0;
        end else begin
            r_lights_q   <= i_lights;
            r_lights_p   <= r_lights_q;
            r_lights_vld <= {r_lights_vld[0], 1'b1};
            r_illegal    <= w_illegal_d;
        end
    end

    assign o_illegal_code = r_illegal;
`else
    assign o_illegal_code = 1'b0;
`endif

endmodule
